// File: rtl/saturating_counter_bank.sv
// Bank of NUM_CH saturating counters sharing one run-time threshold, with optional wrap-on-reload.
// Defining SAT_CNT_DOWN_EN adds per-channel down-count (dn_i) and a zero flag (zero_o).
module saturating_counter_bank #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       clr_i,
  input  logic [WIDTH-1:0]        max_val_i,
  input  logic                    reload_i,
`ifdef SAT_CNT_DOWN_EN
  input  logic [NUM_CH-1:0]       dn_i,
  output logic [NUM_CH-1:0]       zero_o,
`endif
  output logic [NUM_CH*WIDTH-1:0] count_o,
  output logic [NUM_CH-1:0]       sat_o,
  output logic [NUM_CH-1:0]       sat_pulse_o
);

  logic [WIDTH-1:0]  cnt_q [NUM_CH];
  logic [WIDTH-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] sat_pulse_q;
  logic [NUM_CH-1:0] sat_pulse_d;

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cnt_d[ch]       = cnt_q[ch];
      sat_pulse_d[ch] = 1'b0;
      if (clr_i[ch]) begin
        cnt_d[ch] = '0;
      end else if (en_i[ch]) begin
`ifdef SAT_CNT_DOWN_EN
        if (dn_i[ch]) begin
          if (cnt_q[ch] != '0) cnt_d[ch] = cnt_q[ch] - WIDTH'(1);
        end else
`endif
        // Increment only below the threshold, so the all-ones count can never overflow.
        if (cnt_q[ch] < max_val_i) begin
          cnt_d[ch]       = cnt_q[ch] + WIDTH'(1);
          sat_pulse_d[ch] = ((cnt_q[ch] + WIDTH'(1)) == max_val_i);
        end else if (reload_i) begin
          cnt_d[ch] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int ch = 0; ch < NUM_CH; ch++) cnt_q[ch] <= '0;
      sat_pulse_q <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) cnt_q[ch] <= cnt_d[ch];
      sat_pulse_q <= sat_pulse_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign count_o[g*WIDTH +: WIDTH] = cnt_q[g];
    assign sat_o[g]                  = (cnt_q[g] >= max_val_i);
`ifdef SAT_CNT_DOWN_EN
    assign zero_o[g]                 = (cnt_q[g] == '0);
`endif
  end

  assign sat_pulse_o = sat_pulse_q;

endmodule

// File: tb/tb_saturating_counter_bank.sv
// Randomized scoreboard bench for saturating_counter_bank (WIDTH=4, NUM_CH=4).
// Driver updates an integer reference model and queues expected results; a monitor checks after each edge.
module tb_saturating_counter_bank;
  localparam int WIDTH  = 4;
  localparam int NUM_CH = 4;

  typedef struct {
    logic [NUM_CH*WIDTH-1:0] count;
    logic [NUM_CH-1:0]       pulse;
    logic [NUM_CH-1:0]       sat;
  } expT;

  logic                    clk;
  logic                    rstN;
  logic [NUM_CH-1:0]       enVec;
  logic [NUM_CH-1:0]       clrVec;
  logic [WIDTH-1:0]        maxVal;
  logic                    reloadBit;
  logic [NUM_CH*WIDTH-1:0] countOut;
  logic [NUM_CH-1:0]       satOut;
  logic [NUM_CH-1:0]       satPulseOut;
`ifdef SAT_CNT_DOWN_EN
  logic [NUM_CH-1:0]       dnVec;
  logic [NUM_CH-1:0]       zeroOut;
`endif

  int  checks = 0;
  int  errors = 0;
  int  modelCnt [NUM_CH];
  expT expQ [$];

  saturating_counter_bank #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .en_i        (enVec),
    .clr_i       (clrVec),
    .max_val_i   (maxVal),
    .reload_i    (reloadBit),
`ifdef SAT_CNT_DOWN_EN
    .dn_i        (dnVec),
    .zero_o      (zeroOut),
`endif
    .count_o     (countOut),
    .sat_o       (satOut),
    .sat_pulse_o (satPulseOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [NUM_CH*WIDTH-1:0] packModel();
    logic [NUM_CH*WIDTH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i*WIDTH +: WIDTH] = WIDTH'(modelCnt[i]);
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] satModel();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = (modelCnt[i] >= int'(maxVal));
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model, and queue what the next edge must produce.
  task automatic applyStimulus(input logic [NUM_CH-1:0] enV, input logic [NUM_CH-1:0] clrV,
                               input int maxV, input logic rel);
    expT e;
    int  top;
    @(negedge clk);
    enVec     = enV;
    clrVec    = clrV;
    maxVal    = WIDTH'(maxV);
    reloadBit = rel;
`ifdef SAT_CNT_DOWN_EN
    dnVec     = NUM_CH'($urandom) & NUM_CH'($urandom);
`endif
    top = maxV;
    #1;
    checkOutput("satComb", 64'(satOut), 64'(satModel()));
    for (int i = 0; i < NUM_CH; i++) begin
      e.pulse[i] = 1'b0;
      if (clrV[i]) modelCnt[i] = 0;
      else if (enV[i]) begin
`ifdef SAT_CNT_DOWN_EN
        if (dnVec[i]) begin
          if (modelCnt[i] > 0) modelCnt[i] = modelCnt[i] - 1;
        end else
`endif
        if (modelCnt[i] < top) begin
          modelCnt[i] = modelCnt[i] + 1;
          e.pulse[i]  = (modelCnt[i] == top);
        end else if (rel) modelCnt[i] = 0;
      end
    end
    e.count = packModel();
    e.sat   = satModel();
    expQ.push_back(e);
  endtask

  initial begin : monitor
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("count", 64'(countOut), 64'(e.count));
        checkOutput("satPulse", 64'(satPulseOut), 64'(e.pulse));
        checkOutput("sat", 64'(satOut), 64'(e.sat));
      end
    end
  end

  initial begin : driver
    int maxCur;
    logic relCur;
    logic [NUM_CH-1:0] clrR;
    rstN = 1'b0; enVec = '0; clrVec = '0; maxVal = '0; reloadBit = 1'b0;
`ifdef SAT_CNT_DOWN_EN
    dnVec = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) modelCnt[i] = 0;

    #12;
    checkOutput("rstSatMax0", 64'(satOut), 64'hF);
    maxVal = 4'd5;
    #1;
    checkOutput("rstSatMax5", 64'(satOut), 64'h0);
    checkOutput("rstCount", 64'(countOut), 64'h0);
    checkOutput("rstPulse", 64'(satPulseOut), 64'h0);
    @(negedge clk);
    rstN = 1'b1;

    // Channel 0 saturates at 5 and holds.
    for (int k = 0; k < 10; k++) applyStimulus(4'b0001, 4'b0000, 5, 1'b0);
    // Channel 1 divides by 4 in reload mode.
    applyStimulus(4'b0000, 4'b1111, 3, 1'b1);
    for (int k = 0; k < 12; k++) applyStimulus(4'b0010, 4'b0000, 3, 1'b1);
    // Channel 2 reaches 4, threshold drops below it, then reloads.
    for (int k = 0; k < 4; k++) applyStimulus(4'b0100, 4'b0000, 9, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 2, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 2, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 2, 1'b1);
    // Clear beats enable on channel 0 while channel 1 keeps counting.
    applyStimulus(4'b0000, 4'b1111, 12, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(4'b0011, 4'b0000, 12, 1'b0);
    applyStimulus(4'b0011, 4'b0001, 12, 1'b0);
    applyStimulus(4'b0011, 4'b0000, 12, 1'b0);

    // Async reset between edges with counts nonzero.
    for (int k = 0; k < 7; k++) applyStimulus(4'b1111, 4'b0000, 12, 1'b0);
    @(negedge clk);
    #1;
    rstN = 1'b0; enVec = '0; clrVec = '0;
    #1;
    checkOutput("midRstCount", 64'(countOut), 64'h0);
    checkOutput("midRstPulse", 64'(satPulseOut), 64'h0);
    rstN = 1'b1;
    for (int i = 0; i < NUM_CH; i++) modelCnt[i] = 0;

    // Threshold zero: always saturated, never pulses.
    for (int k = 0; k < 8; k++) applyStimulus(NUM_CH'($urandom), 4'b0000, 0, k[0]);

    maxCur = 6; relCur = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: maxCur = 0;
          1: maxCur = 15;
          default: maxCur = $urandom_range(1, 14);
        endcase
      end
      if ($urandom_range(0, 31) == 0) relCur = ~relCur;
      clrR = '0;
      for (int i = 0; i < NUM_CH; i++) clrR[i] = ($urandom_range(0, 11) == 0);
      applyStimulus(NUM_CH'($urandom), clrR, maxCur, relCur);
    end

    repeat (3) @(negedge clk);
    checkOutput("queueDrain", 64'(expQ.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
